// File: rtl/mc_window_gen.sv
// Multi-channel 3x3 sliding-window generator for raster-scanned frames.
// Two line buffers supply the rows above; a one-deep output register handles backpressure.
module mc_window_gen #(
   parameter int CH    = 2,
   parameter int DW    = 16,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CH*DW-1:0]       i_data,
   input  logic                   i_data_valid,
   output logic                   i_ready,
   input  logic                   i_flush,
   output logic [CH*9*DW-1:0]     o_window,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_eof
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic             take;
   logic             qualify;
   logic             last_col;
   logic             last_row;
   logic [CH*DW-1:0] line1 [IMG_W];
   logic [CH*DW-1:0] line2 [IMG_W];
   logic [CH*DW-1:0] up1;
   logic [CH*DW-1:0] up2;

   assign i_ready  = !o_valid || o_ready;
   // A flushed pixel is dropped, so it never counts as taken.
   assign take     = i_data_valid && i_ready && !i_flush;
   assign last_col = (col == CW'(IMG_W - 1));
   assign last_row = (row == RW'(IMG_H - 1));
   assign qualify  = take && (col >= CW'(2)) && (row >= RW'(2));
   assign up1      = line1[col];
   assign up2      = line2[col];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (i_flush) begin
         col <= '0;
         row <= '0;
      end else if (take) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // NOTE: line buffers are storage, not control state; they carry no reset because
   // the row>=2 qualification guarantees both rows are rewritten before they are read.
   always_ff @(posedge clk) begin
      if (take) begin
         line2[col] <= up1;
         line1[col] <= i_data;
      end
   end

   // The window shift register doubles as the output register; it can only move
   // when i_ready is high, so a stalled window is held automatically.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_window <= '0;
      end else if (take) begin
         for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 3; r++) begin
               o_window[(c*9 + r*3)*DW     +: DW] <= o_window[(c*9 + r*3 + 1)*DW +: DW];
               o_window[(c*9 + r*3 + 1)*DW +: DW] <= o_window[(c*9 + r*3 + 2)*DW +: DW];
            end
            o_window[(c*9 + 2)*DW +: DW] <= up2[c*DW +: DW];
            o_window[(c*9 + 5)*DW +: DW] <= up1[c*DW +: DW];
            o_window[(c*9 + 8)*DW +: DW] <= i_data[c*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_eof   <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
         o_eof   <= 1'b0;
      end else if (qualify) begin
         o_valid <= 1'b1;
         o_eof   <= last_col && last_row;
      end else if (o_ready) begin
         o_valid <= 1'b0;
         o_eof   <= 1'b0;
      end
   end

endmodule
